// File: rtl/beat_gen_pkg.sv
// beat_gen_pkg: types and the default length width shared by the beat framing stage
// and the downstream length-counting consumer.
package beat_gen_pkg;

    localparam int LEN_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/beat_gen.sv
// beat_gen: turns one length command into len+1 framed beats (length, index, last flag).
// Optional macro BEAT_GEN_BACK2BACK_EN accepts the next command on the last-beat handshake.
module beat_gen
    import beat_gen_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_val,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_rdy,
    output logic             beat_val,
    output logic [LEN_W-1:0] beat_len,
    output logic [LEN_W-1:0] beat_idx,
    output logic             beat_last,
    input  logic             beat_rdy,
    output logic             pkt_done
);

    state_e           state;
    state_e           state_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] idx_reg;
    logic [LEN_W-1:0] idx_next;
    logic             pkt_done_next;

    assign beat_len  = len_reg;
    assign beat_idx  = idx_reg;
    assign beat_last = (idx_reg == len_reg);

    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    always_comb begin
        state_next    = state;
        len_next      = len_reg;
        idx_next      = idx_reg;
        pkt_done_next = 1'b0;
        cmd_rdy       = 1'b0;
        beat_val      = 1'b0;

        case (state)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    len_next   = cmd_len;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end

            SEND: begin
                beat_val = 1'b1;
`ifdef BEAT_GEN_BACK2BACK_EN
                cmd_rdy  = beat_rdy & beat_last;
`endif
                if (beat_rdy) begin
                    if (!beat_last) begin
                        // idx_reg never passes len_reg, so this increment cannot wrap.
                        idx_next = idx_reg + LEN_W'(1);
                    end else begin
                        pkt_done_next = 1'b1;
                        state_next    = IDLE;
`ifdef BEAT_GEN_BACK2BACK_EN
                        if (cmd_val) begin
                            len_next   = cmd_len;
                            idx_next   = '0;
                            state_next = SEND;
                        end
`endif
                    end
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_reg  <= '0;
            idx_reg  <= '0;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_next;
            len_reg  <= len_next;
            idx_reg  <= idx_next;
            pkt_done <= pkt_done_next;
        end
    end

endmodule

// File: tb/tb_beat_gen.sv
// tb_beat_gen: table-driven directed vectors plus hand-written multi-cycle sequences for beat_gen.
// Expected values follow BEAT_GEN_BACK2BACK_EN when the bench is built with it.
module tb_beat_gen;

`ifdef BEAT_GEN_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_val;
    logic [7:0] cmd_len;
    logic       cmd_rdy;
    logic       beat_val;
    logic [7:0] beat_len;
    logic [7:0] beat_idx;
    logic       beat_last;
    logic       beat_rdy;
    logic       pkt_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beat_gen #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_val   (cmd_val),
        .cmd_len   (cmd_len),
        .cmd_rdy   (cmd_rdy),
        .beat_val  (beat_val),
        .beat_len  (beat_len),
        .beat_idx  (beat_idx),
        .beat_last (beat_last),
        .beat_rdy  (beat_rdy),
        .pkt_done  (pkt_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       cv;
        logic [7:0] len;
        logic       br;
        logic       rdy;
        logic       bv;
        logic [7:0] blen;
        logic [7:0] idx;
        logic       last;
        logic       done;
    } vec_t;

    vec_t vecs[15];
    logic [7:0] b2b_idx[5];
    logic [7:0] b2b_len[5];

    // Outputs must hold while a beat is stalled; reset is the only thing allowed to break that.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_len;
    logic [7:0] prev_idx;
    logic       prev_last;

    always @(posedge clk) begin
        if (prev_stall) begin
            check("stall beat_val", 32'(beat_val), 32'd1);
            check("stall beat_len", 32'(beat_len), 32'(prev_len));
            check("stall beat_idx", 32'(beat_idx), 32'(prev_idx));
            check("stall beat_last", 32'(beat_last), 32'(prev_last));
        end
        prev_stall <= (beat_val === 1'b1) && (beat_rdy === 1'b0) && (rst === 1'b0);
        prev_len   <= beat_len;
        prev_idx   <= beat_idx;
        prev_last  <= beat_last;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbeats;
        int nlast;
        int ndone;
        int acc;
        int first_c;
        int last_c;
        int last_idx;
        bit found;

        //               cv    len    br   | rdy   bv    blen   idx    last  done
        vecs[0]  = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd3, 8'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'd0, 1'b1, B2B,  1'b1, 8'd3, 8'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd3, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'd0, 1'b1, B2B,  1'b1, 8'd0, 8'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 8'd2, 8'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'd9, 1'b1, B2B,  1'b1, 8'd2, 8'd2, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd2, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd2, 1'b1, 1'b0};

        b2b_idx[0] = 8'd0; b2b_idx[1] = 8'd1; b2b_idx[2] = 8'd0; b2b_idx[3] = 8'd1; b2b_idx[4] = 8'd2;
        b2b_len[0] = 8'd1; b2b_len[1] = 8'd1; b2b_len[2] = 8'd2; b2b_len[3] = 8'd2; b2b_len[4] = 8'd2;

        rst      = 1'b1;
        cmd_val  = 1'b0;
        cmd_len  = 8'd0;
        beat_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, cmd_len=3, single beat, and backpressure with cmd_len changing mid-packet.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            cmd_val  = vecs[i].cv;
            cmd_len  = vecs[i].len;
            beat_rdy = vecs[i].br;
            #1;
            check($sformatf("row%0d cmd_rdy", i), 32'(cmd_rdy), 32'(vecs[i].rdy));
            check($sformatf("row%0d beat_val", i), 32'(beat_val), 32'(vecs[i].bv));
            check($sformatf("row%0d beat_len", i), 32'(beat_len), 32'(vecs[i].blen));
            check($sformatf("row%0d beat_idx", i), 32'(beat_idx), 32'(vecs[i].idx));
            check($sformatf("row%0d beat_last", i), 32'(beat_last), 32'(vecs[i].last));
            check($sformatf("row%0d pkt_done", i), 32'(pkt_done), 32'(vecs[i].done));
        end

        // Full range: 256 beats, last index 0xFF, one pkt_done.
        @(negedge clk);
        cmd_val  = 1'b1;
        cmd_len  = 8'd255;
        beat_rdy = 1'b1;
        #1 check("full cmd_rdy", 32'(cmd_rdy), 32'd1);
        @(negedge clk);
        cmd_val  = 1'b0;
        cmd_len  = 8'd0;
        nbeats   = 0;
        nlast    = 0;
        ndone    = 0;
        last_idx = -1;
        for (int c = 0; c < 260; c++) begin
            #1;
            if (beat_val && beat_rdy) begin
                check("full beat_idx", 32'(beat_idx), 32'(nbeats[7:0]));
                if (beat_last) begin
                    nlast++;
                    last_idx = int'(beat_idx);
                end
                nbeats++;
            end
            if (pkt_done) ndone++;
            @(negedge clk);
        end
        check("full beats", 32'(nbeats), 32'd256);
        check("full last count", 32'(nlast), 32'd1);
        check("full last idx", 32'(last_idx), 32'd255);
        check("full pkt_done count", 32'(ndone), 32'd1);

        // Back-to-back commands 1 then 2 with cmd_val held high.
        acc     = 0;
        nbeats  = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 20 && nbeats < 5; c++) begin
            @(negedge clk);
            cmd_val  = (acc < 2);
            cmd_len  = (acc == 0) ? 8'd1 : 8'd2;
            beat_rdy = 1'b1;
            #1;
            if (cmd_val && cmd_rdy) acc++;
            if (beat_val && beat_rdy) begin
                check($sformatf("b2b beat%0d idx", nbeats), 32'(beat_idx), 32'(b2b_idx[nbeats]));
                check($sformatf("b2b beat%0d len", nbeats), 32'(beat_len), 32'(b2b_len[nbeats]));
                if (first_c < 0) first_c = c;
                last_c = c;
                nbeats++;
            end
        end
        cmd_val = 1'b0;
        check("b2b beats", 32'(nbeats), 32'd5);
        check("b2b commands", 32'(acc), 32'd2);
        check("b2b span cycles", 32'(last_c - first_c + 1), B2B ? 32'd5 : 32'd6);
        @(negedge clk);
        #1;
        check("b2b idle beat_val", 32'(beat_val), 32'd0);
        check("b2b pkt_done", 32'(pkt_done), 32'd1);

        // Reset mid-packet at idx 2, then a fresh cmd_len=1.
        @(negedge clk);
        cmd_val  = 1'b1;
        cmd_len  = 8'd5;
        beat_rdy = 1'b1;
        @(negedge clk);
        cmd_val = 1'b0;
        cmd_len = 8'd0;
        found   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (beat_val && beat_idx == 8'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst reached idx2", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        cmd_val = 1'b1;
        cmd_len = 8'd1;
        #1;
        check("rst beat_val", 32'(beat_val), 32'd0);
        check("rst cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("rst pkt_done", 32'(pkt_done), 32'd0);
        check("rst beat_last", 32'(beat_last), 32'd1);
        check("rst beat_idx", 32'(beat_idx), 32'd0);
        check("rst beat_len", 32'(beat_len), 32'd0);
        @(negedge clk);
        cmd_val = 1'b0;
        cmd_len = 8'd0;
        #1;
        check("post-rst beat0 val", 32'(beat_val), 32'd1);
        check("post-rst beat0 idx", 32'(beat_idx), 32'd0);
        check("post-rst beat0 len", 32'(beat_len), 32'd1);
        check("post-rst beat0 last", 32'(beat_last), 32'd0);
        @(negedge clk);
        #1;
        check("post-rst beat1 idx", 32'(beat_idx), 32'd1);
        check("post-rst beat1 last", 32'(beat_last), 32'd1);
        @(negedge clk);
        #1;
        check("post-rst pkt_done", 32'(pkt_done), 32'd1);
        check("post-rst idle", 32'(beat_val), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_gen.md
# beat_gen

Upstream framing stage for the length-counting consumer: accepts one length command per packet on a valid/ready port and emits a stream of `len+1` beats on a valid/ready output. Each beat carries the packet length, a beat index and a last flag. The consumer counts beats from 0 up to `len` inclusive against this stream. The block owns packet framing only; no payload is stored.

## Interface
- `LEN_W`, 8, width of the length field and the beat index
- `clk` input 1 system clock, all logic on posedge
- `rst` input 1 synchronous, active-high reset
- `cmd_val` input 1 command valid
- `cmd_len` input LEN_W packet length; the packet is `cmd_len+1` beats
- `cmd_rdy` output 1 command accepted when `cmd_val & cmd_rdy`
- `beat_val` output 1 beat valid
- `beat_len` output LEN_W length of the current packet, constant for the whole packet
- `beat_idx` output LEN_W index of the current beat, 0..`beat_len`
- `beat_last` output 1 high when `beat_idx == beat_len`
- `beat_rdy` input 1 downstream accepts the beat when `beat_val & beat_rdy`
- `pkt_done` output 1 one-cycle pulse, registered, in the cycle after the last-beat handshake

## Operation
- State machine `state_e`: IDLE, SEND.
- IDLE:
  - `cmd_rdy=1`, `beat_val=0`.
  - On a `cmd_val` handshake: `len_reg<=cmd_len`, `idx_reg<=0`, go to SEND.
- SEND:
  - `beat_val=1`, `cmd_rdy=0` (except as noted under Configuration).
  - On a beat handshake with `idx_reg!=len_reg`: `idx_reg<=idx_reg+1`.
  - On a beat handshake with `idx_reg==len_reg`: go to IDLE and set `pkt_done` next cycle.
- Without a handshake, all state holds. Outputs stay stable while `beat_val & !beat_rdy`; this is a valid/ready rule and a bench assertion.
- `beat_len=len_reg`, `beat_idx=idx_reg`, `beat_last=(idx_reg==len_reg)`; all are combinational from registers.
- Arithmetic: the increment is LEN_W bits. `idx_reg` never exceeds `len_reg`, so no wrap occurs.
  - `cmd_len=0` gives a single beat with `beat_last=1`.
  - `cmd_len=2^LEN_W-1` gives 2^LEN_W beats, with the final `beat_idx` all ones.
- `cmd_len` is sampled only on the handshake; changes on `cmd_len` during SEND are ignored.
- Reset (including mid-packet):
  - `state<=IDLE`, `len_reg<=0`, `idx_reg<=0`, `pkt_done<=0`.
  - The packet in flight is abandoned with no partial-packet flush.
  - In the cycle after reset deasserts: `beat_val=0`, `cmd_rdy=1`, `beat_last=1` (0==0, masked by `beat_val=0`).
- No path from `beat_rdy` to `beat_val`. No path from `cmd_val` to any output.

## Timing
- Command handshake in cycle N gives the first beat valid in cycle N+1.
- Throughput is one beat per cycle while `beat_rdy=1`.
- Default build: the packet occupies `len+1` beat cycles plus one IDLE cycle. Back-to-back commands therefore leave one bubble.
- `pkt_done` is asserted in the cycle after the last-beat handshake, coinciding with IDLE or with the next packet's first beat.
- `cmd_rdy` is registered-state only by default, with no combinational input dependency.

## Configuration
- `BEAT_GEN_BACK2BACK_EN`:
  - Defined: `cmd_rdy = (state==IDLE) | (state==SEND & beat_rdy & beat_last)`.
  - A command accepted on the last-beat handshake cycle reloads `len_reg` and `idx_reg<=0` and stays in SEND, giving zero bubbles between packets.
  - This introduces a combinational `beat_rdy -> cmd_rdy` path. Integrators must not close it through the upstream source.
- Undefined: the behaviour described above, with one bubble per packet.

## Structure
- Shared package `beat_gen_pkg`: `state_e` (1-bit enum IDLE=0, SEND=1) and the `LEN_W` default constant shared with the consumer.
- Single module; no sub-module is warranted. The index counter is inline.

## Test plan
- Reset, then one command: `cmd_len=3` with `beat_rdy=1` -> beats idx 0,1,2,3 in consecutive cycles, `beat_len=3` throughout, `beat_last` only on idx 3, `pkt_done` one cycle later.
- Single beat: `cmd_len=0` -> one beat with `beat_last=1`; `cmd_rdy` high again the next cycle.
- Backpressure: `cmd_len=2`, `beat_rdy` toggled 1,0,0,1,1 -> idx 0 accepted, idx 1 held stable for 2 cycles, then idx 1 and 2; outputs unchanged while stalled.
- Full range: `cmd_len=255` -> 256 beats, final idx 0xFF, no wrap, single `pkt_done`.
- Back-to-back: commands 1 then 2, `cmd_val` held high -> default build gives 5 beats in 6 cycles (one bubble); with `BEAT_GEN_BACK2BACK_EN`, 5 beats in 5 cycles.
- Reset mid-op: `cmd_len=5`, `rst` pulsed at idx 2 -> next cycle `beat_val=0`, `cmd_rdy=1`, no `pkt_done`; a new `cmd_len=1` gives idx 0,1.
